dijkstra_run_sequencer: RTL and testbench



---
 rtl/dijkstra_run_sequencer_if.sv | 31 +++
 rtl/dijkstra_run_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_dijkstra_run_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dijkstra_run_sequencer_if.sv
// Avalon-MM slave bus between the host fabric and the run sequencer.
// The sequencer uses the slave view; the host (or bench) uses master.
interface dijkstra_run_sequencer_if;
   logic        avs_s1_chipselect_iCS;
   logic        avs_s1_write_iWR;
   logic        avs_s1_read_iRD;
   logic [10:0] avs_s1_address_iADDR;
   logic [15:0] avs_s1_writedata_iDATA;
   logic [15:0] avs_s1_readdata_oDATA;
   logic        avs_s1_irq_oIRQ;

   modport slave (
      input  avs_s1_chipselect_iCS,
      input  avs_s1_write_iWR,
      input  avs_s1_read_iRD,
      input  avs_s1_address_iADDR,
      input  avs_s1_writedata_iDATA,
      output avs_s1_readdata_oDATA,
      output avs_s1_irq_oIRQ
   );

   modport master (
      output avs_s1_chipselect_iCS,
      output avs_s1_write_iWR,
      output avs_s1_read_iRD,
      output avs_s1_address_iADDR,
      output avs_s1_writedata_iDATA,
      input  avs_s1_readdata_oDATA,
      input  avs_s1_irq_oIRQ
   );
endinterface

// File: rtl/dijkstra_run_sequencer.sv
// Runs the Dijkstra core end-to-end: reset, wait for completion, then
// step each node's result out through clk_NIOS into a readable buffer.
module dijkstra_run_sequencer #(
   parameter int          MAX_NODES      = 512,
   parameter logic [2:0]  DONE_STATE     = 3'd4,
   parameter int          RST_CYCLES     = 4,
   parameter int          SETTLE_CYCLES  = 2,
   parameter int          PULSE_CYCLES   = 2,
   parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
   input  logic                   avs_s1_clk_iCLK,
   input  logic                   avs_s1_reset_iRST,
   dijkstra_run_sequencer_if.slave avs,
   output logic                   core_reset_o,
   output logic                   core_clk_nios_o,
   output logic [8:0]             core_start_o,
   output logic [8:0]             core_trans_count_o,
   input  logic [2:0]             core_state_i,
   input  logic [8:0]             core_neighbor_i,
   input  logic [13:0]            core_distance_i
);

   typedef enum logic [3:0] {
      IDLE, RST_CORE, WAIT_DONE, XFER_SETUP,
      CLK_HI, CLK_LO, CAPTURE, DONE, ERROR
   } state_t;

   localparam logic [23:0] RST_LAST    = 24'(RST_CYCLES - 1);
   localparam logic [23:0] SETTLE_LAST = 24'(SETTLE_CYCLES - 1);
   localparam logic [23:0] PULSE_LAST  = 24'(PULSE_CYCLES - 1);
   localparam logic [23:0] TMO_LAST    = TIMEOUT_CYCLES - 24'd1;
   localparam logic [9:0]  MAX_N       = 10'(MAX_NODES);

   logic        clk;
   logic        rst;
   state_t      state;
   state_t      state_n;
   logic [23:0] cnt;
   logic        go_q;
   logic        abort_q;
   logic [8:0]  start_q;
   logic [9:0]  node_count_q;
   logic [9:0]  n_q;
   logic [9:0]  n_clamp;
   logic [9:0]  progress;
   logic        done;
   logic        error;
   logic        irq;
   logic        busy;
   logic        last_entry;
   logic        start_run;
   logic        enter_done;
   logic        enter_error;
   logic        wr;
   logic        rd;
   logic        is_reg;
   logic [8:0]  reg_addr;
   logic [15:0] wdata;
   logic [15:0] rdata;

   logic [8:0]  nbr_mem  [MAX_NODES];
   logic [13:0] dist_mem [MAX_NODES];

   assign clk      = avs_s1_clk_iCLK;
   assign rst      = avs_s1_reset_iRST;
   assign wr       = avs.avs_s1_chipselect_iCS & avs.avs_s1_write_iWR;
   assign rd       = avs.avs_s1_chipselect_iCS & avs.avs_s1_read_iRD;
   assign is_reg   = (avs.avs_s1_address_iADDR[10:9] == 2'b00);
   assign reg_addr = avs.avs_s1_address_iADDR[8:0];
   assign wdata    = avs.avs_s1_writedata_iDATA;
   assign avs.avs_s1_irq_oIRQ = irq;

   always_comb begin
      busy        = !(state inside {IDLE, DONE, ERROR});
      last_entry  = (({1'b0, core_trans_count_o} + 10'd1) == n_q);
      n_clamp     = (node_count_q > MAX_N) ? MAX_N : node_count_q;
      start_run   = go_q && !busy;
      enter_done  = (state_n == DONE) && (state != DONE);
      enter_error = (state_n == ERROR) && (state != ERROR);
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE, DONE, ERROR:
            if (go_q) state_n = RST_CORE;
         RST_CORE:
            if (cnt == RST_LAST) state_n = WAIT_DONE;
         WAIT_DONE:
            if (core_state_i == DONE_STATE)
               state_n = (n_q == 10'd0) ? DONE : XFER_SETUP;
            else if (cnt == TMO_LAST)
               state_n = ERROR;
         XFER_SETUP:
            if (cnt == SETTLE_LAST) state_n = CLK_HI;
         CLK_HI:
            if (cnt == PULSE_LAST) state_n = CLK_LO;
         CLK_LO:
            if (cnt == PULSE_LAST) state_n = CAPTURE;
         CAPTURE:
            state_n = last_entry ? DONE : XFER_SETUP;
         default:
            state_n = IDLE;
      endcase
      // abort overrides whatever the sequence wanted to do next
      if (abort_q && busy) state_n = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state              <= IDLE;
         cnt                <= '0;
         core_reset_o       <= 1'b1;
         core_clk_nios_o    <= 1'b0;
         core_trans_count_o <= '0;
      end else begin
         state           <= state_n;
         cnt             <= (state_n != state) ? '0 : cnt + 24'd1;
         core_reset_o    <= state_n inside {IDLE, RST_CORE, ERROR};
         core_clk_nios_o <= (state_n == CLK_HI);
         if (state == WAIT_DONE && state_n == XFER_SETUP)
            core_trans_count_o <= '0;
         else if (state == CAPTURE && state_n == XFER_SETUP)
            core_trans_count_o <= core_trans_count_o + 9'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         go_q         <= 1'b0;
         abort_q      <= 1'b0;
         start_q      <= '0;
         node_count_q <= '0;
      end else begin
         go_q    <= wr && is_reg && reg_addr == 9'd0
                    && wdata[0] && !wdata[1];
         abort_q <= wr && is_reg && reg_addr == 9'd0 && wdata[1];
         if (wr && is_reg && reg_addr == 9'd2 && !busy)
            start_q <= wdata[8:0];
         if (wr && is_reg && reg_addr == 9'd3 && !busy)
            node_count_q <= wdata[9:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done         <= 1'b0;
         error        <= 1'b0;
         irq          <= 1'b0;
         progress     <= '0;
         n_q          <= '0;
         core_start_o <= '0;
      end else begin
         if (wr && is_reg && reg_addr == 9'd1) begin
            if (wdata[1]) done  <= 1'b0;
            if (wdata[2]) error <= 1'b0;
            if (wdata[1] || wdata[2]) irq <= 1'b0;
         end
         if (start_run) begin
            done         <= 1'b0;
            error        <= 1'b0;
            irq          <= 1'b0;
            progress     <= '0;
            n_q          <= n_clamp;
            core_start_o <= start_q;
         end
         if (state == CAPTURE)
            progress <= {1'b0, core_trans_count_o} + 10'd1;
         if (enter_done) begin
            done <= 1'b1;
            irq  <= 1'b1;
         end
         if (enter_error) begin
            error <= 1'b1;
            irq   <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == CAPTURE) begin
         nbr_mem[core_trans_count_o]  <= core_neighbor_i;
         dist_mem[core_trans_count_o] <= core_distance_i;
      end
   end

   always_comb begin
      rdata = '0;
      case (avs.avs_s1_address_iADDR[10:9])
         2'b00:
            case (reg_addr)
               9'd1:    rdata = {13'd0, error, done, busy};
               9'd2:    rdata = {7'd0, start_q};
               9'd3:    rdata = {6'd0, node_count_q};
               9'd4:    rdata = {6'd0, progress};
               default: rdata = '0;
            endcase
         2'b10:   rdata = {7'd0, nbr_mem[reg_addr]};
         2'b11:   rdata = {2'd0, dist_mem[reg_addr]};
         default: rdata = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         avs.avs_s1_readdata_oDATA <= '0;
      else if (rd)
         avs.avs_s1_readdata_oDATA <= rdata;
   end

endmodule

// File: tb/tb_dijkstra_run_sequencer.sv
// Directed and randomized runs of the sequencer against a simple core
// model; results are predicted from the documented run timing.
module tb_dijkstra_run_sequencer;
   localparam int CORE_LAT = 20;
   localparam int TMO      = 100;
   localparam int RSTC     = 4;
   localparam int SETTLE   = 2;
   localparam int PULSE    = 2;
   localparam int MAXN     = 512;
   localparam int ENTRY    = SETTLE + 2 * PULSE + 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        core_reset;
   logic        core_clk_nios;
   logic [8:0]  core_start;
   logic [8:0]  core_tc;
   logic [2:0]  core_state;
   logic [8:0]  core_nbr = '0;
   logic [13:0] core_dist = '0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int core_cnt = 0;
   bit never_done = 1'b0;
   logic [8:0]  nbr_ref  [MAXN];
   logic [13:0] dist_ref [MAXN];
   int pulse_tc[$];
   int pulse_st[$];

   dijkstra_run_sequencer_if avs();

   dijkstra_run_sequencer #(
      .TIMEOUT_CYCLES(24'(TMO))
   ) dut (
      .avs_s1_clk_iCLK   (clk),
      .avs_s1_reset_iRST (rst),
      .avs               (avs),
      .core_reset_o      (core_reset),
      .core_clk_nios_o   (core_clk_nios),
      .core_start_o      (core_start),
      .core_trans_count_o(core_tc),
      .core_state_i      (core_state),
      .core_neighbor_i   (core_nbr),
      .core_distance_i   (core_dist)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // core model: finishes CORE_LAT cycles after its reset is released
   always @(posedge clk) begin
      if (core_reset) core_cnt <= 0;
      else if (core_cnt < 100000) core_cnt <= core_cnt + 1;
   end
   assign core_state = (!never_done && core_cnt >= CORE_LAT) ? 3'd4 : 3'd1;

   always @(posedge core_clk_nios) begin
      pulse_tc.push_back(int'(core_tc));
      pulse_st.push_back(int'(core_start));
      core_nbr  <= nbr_ref[core_tc];
      core_dist <= dist_ref[core_tc];
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic bus_wr(input int a, input int d);
      @(negedge clk);
      avs.avs_s1_chipselect_iCS  = 1'b1;
      avs.avs_s1_write_iWR       = 1'b1;
      avs.avs_s1_address_iADDR   = 11'(a);
      avs.avs_s1_writedata_iDATA = 16'(d);
      @(negedge clk);
      avs.avs_s1_chipselect_iCS = 1'b0;
      avs.avs_s1_write_iWR      = 1'b0;
   endtask

   task automatic bus_rd(input int a, output logic [15:0] d);
      @(negedge clk);
      avs.avs_s1_chipselect_iCS = 1'b1;
      avs.avs_s1_read_iRD       = 1'b1;
      avs.avs_s1_address_iADDR  = 11'(a);
      @(negedge clk);
      avs.avs_s1_chipselect_iCS = 1'b0;
      avs.avs_s1_read_iRD       = 1'b0;
      d = avs.avs_s1_readdata_oDATA;
   endtask

   task automatic rd_chk(input string tag, input int a, input int exp);
      logic [15:0] d;
      bus_rd(a, d);
      chk(tag, 32'(d), 32'(exp));
   endtask

   task automatic fill_refs();
      for (int i = 0; i < MAXN; i++) begin
         nbr_ref[i]  = 9'($urandom);
         dist_ref[i] = 14'($urandom);
      end
   endtask

   task automatic wait_irq(input int cw, input int limit, output int lat);
      lat = -1;
      for (int k = 0; k < limit; k++) begin
         if (avs.avs_s1_irq_oIRQ === 1'b1) begin
            lat = cyc - cw;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic do_run(input string tag, input int st, input int nc,
                         input bit poke);
      int n;
      int cw;
      int lat;
      int bad;
      int idx[$];
      n = (nc > MAXN) ? MAXN : nc;
      fill_refs();
      never_done = 1'b0;
      bus_wr(2, st);
      bus_wr(3, nc);
      pulse_tc.delete();
      pulse_st.delete();
      bus_wr(0, 1);
      cw = cyc;
      if (poke) begin
         bus_wr(2, 9'h1AA ^ st);
         bus_wr(3, 7);
      end
      wait_irq(cw, 8000, lat);
      chk({tag, " latency"}, lat,
          1 + RSTC + CORE_LAT + 1 + n * ENTRY);
      chk({tag, " pulses"}, pulse_tc.size(), n);
      bad = 0;
      for (int i = 0; i < pulse_tc.size(); i++)
         if (pulse_tc[i] != i || pulse_st[i] != st) bad++;
      chk({tag, " pulse seq"}, bad, 0);
      rd_chk({tag, " progress"}, 4, n);
      rd_chk({tag, " status"}, 1, 2);
      rd_chk({tag, " start reg"}, 2, st);
      rd_chk({tag, " count reg"}, 3, nc);
      chk({tag, " irq"}, avs.avs_s1_irq_oIRQ, 1);
      if (n <= 16) begin
         for (int i = 0; i < n; i++) idx.push_back(i);
      end else begin
         idx.push_back(0);
         idx.push_back(n - 1);
         idx.push_back($urandom_range(1, n - 2));
      end
      foreach (idx[j]) begin
         rd_chk({tag, " nbr"}, 'h400 + idx[j], nbr_ref[idx[j]]);
         rd_chk({tag, " dist"}, 'h600 + idx[j], dist_ref[idx[j]]);
      end
      bus_wr(1, 2);
      chk({tag, " irq w1c"}, avs.avs_s1_irq_oIRQ, 0);
      rd_chk({tag, " status w1c"}, 1, 0);
   endtask

   initial begin
      int cw;
      int lat;
      avs.avs_s1_chipselect_iCS  = 1'b0;
      avs.avs_s1_write_iWR       = 1'b0;
      avs.avs_s1_read_iRD        = 1'b0;
      avs.avs_s1_address_iADDR   = '0;
      avs.avs_s1_writedata_iDATA = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst core_reset", core_reset, 1);
      chk("rst clk_nios", core_clk_nios, 0);
      chk("rst start", core_start, 0);
      chk("rst trans", core_tc, 0);
      chk("rst irq", avs.avs_s1_irq_oIRQ, 0);
      rst = 1'b0;
      rd_chk("rst status", 1, 0);
      rd_chk("rst start reg", 2, 0);
      rd_chk("rst count reg", 3, 0);
      rd_chk("rst progress", 4, 0);

      // GO together with ABORT must not start anything
      pulse_tc.delete();
      bus_wr(3, 2);
      bus_wr(0, 3);
      repeat (10) @(negedge clk);
      rd_chk("goabort status", 1, 0);
      chk("goabort pulses", pulse_tc.size(), 0);
      chk("goabort core_reset", core_reset, 1);

      do_run("basic", 5, 3, 1'b0);
      do_run("rand1", $urandom_range(0, 511), $urandom_range(1, 12), 1'b0);
      do_run("rand2", $urandom_range(0, 511), $urandom_range(1, 12), 1'b1);
      do_run("zero", 9, 0, 1'b0);

      // core never finishes: timeout to ERROR
      never_done = 1'b1;
      bus_wr(3, 2);
      pulse_tc.delete();
      bus_wr(0, 1);
      cw = cyc;
      wait_irq(cw, 1000, lat);
      chk("tmo latency", lat, 1 + RSTC + TMO);
      rd_chk("tmo status", 1, 4);
      chk("tmo irq", avs.avs_s1_irq_oIRQ, 1);
      chk("tmo core_reset", core_reset, 1);
      chk("tmo pulses", pulse_tc.size(), 0);
      bus_wr(1, 4);
      chk("tmo irq w1c", avs.avs_s1_irq_oIRQ, 0);
      never_done = 1'b0;

      // abort just after the second capture
      fill_refs();
      bus_wr(2, 3);
      bus_wr(3, 5);
      pulse_tc.delete();
      pulse_st.delete();
      bus_wr(0, 1);
      for (int k = 0; k < 2000; k++) begin
         if (pulse_tc.size() == 2 && core_clk_nios == 1'b0) break;
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
      bus_wr(0, 2);
      @(negedge clk);
      chk("abort core_reset", core_reset, 1);
      chk("abort clk_nios", core_clk_nios, 0);
      repeat (30) @(negedge clk);
      chk("abort pulses", pulse_tc.size(), 2);
      rd_chk("abort status", 1, 0);
      rd_chk("abort progress", 4, 2);
      chk("abort irq", avs.avs_s1_irq_oIRQ, 0);
      rd_chk("abort nbr1", 'h401, nbr_ref[1]);
      rd_chk("abort dist0", 'h600, dist_ref[0]);

      do_run("clamp", $urandom_range(0, 511), 600, 1'b0);

      // asynchronous reset while clk_NIOS is high
      bus_wr(3, 3);
      bus_wr(2, 7);
      bus_wr(0, 1);
      for (int k = 0; k < 2000; k++) begin
         if (core_clk_nios == 1'b1) break;
         @(negedge clk);
      end
      chk("midrst pulse seen", core_clk_nios, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst clk_nios", core_clk_nios, 0);
      chk("midrst core_reset", core_reset, 1);
      chk("midrst start", core_start, 0);
      chk("midrst irq", avs.avs_s1_irq_oIRQ, 0);
      @(negedge clk);
      rst = 1'b0;
      rd_chk("midrst status", 1, 0);
      rd_chk("midrst progress", 4, 0);
      rd_chk("midrst start reg", 2, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
